// File: rtl/network_source_sched.sv
// Network dispatch source with a per-input ring of future charges, so a spike can be
// scheduled up to DELAY_DEPTH timesteps ahead of the one currently staged on net_inp.
module network_source_sched #(
  parameter int NUM_INP      = 4,
  parameter int CHARGE_WIDTH = 8,
  parameter int RUN_WIDTH    = 16,
  parameter int DELAY_DEPTH  = 4,
  parameter int SRC_WIDTH    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            src_valid,
  output logic                            src_ready,
  input  logic [SRC_WIDTH-1:0]            src,
  input  logic                            net_ready,
  output logic                            net_valid,
  output logic                            net_rst,
  output logic [NUM_INP*CHARGE_WIDTH-1:0] net_inp,
  output logic                            drop,
  output logic                            sat
);
  // Both handshakes: a transfer happens on a posedge where valid && ready are both 1.
  localparam int CW     = CHARGE_WIDTH;
  localparam int IDX_W  = $clog2(NUM_INP);
  localparam int IDX_FW = (IDX_W > 0) ? IDX_W : 1;
  localparam int DLY_W  = $clog2(DELAY_DEPTH + 1);
  localparam int PTR_W  = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 1;

  typedef enum logic [2:0] {OP_NOP = 3'd0, OP_RUN = 3'd1, OP_SPK = 3'd2, OP_CLR = 3'd3} op_e;

  logic [2:0]           opc;
  logic [RUN_WIDTH-1:0] run_f;
  logic [IDX_FW-1:0]    idx_f;
  logic [CW-1:0]        val_f;
  logic [DLY_W-1:0]     dly_f;
  logic                 unused_src;

  assign opc        = src[SRC_WIDTH-1 -: 3];
  assign run_f      = src[SRC_WIDTH-4 -: RUN_WIDTH];
  assign val_f      = src[SRC_WIDTH-4-IDX_W -: CW];
  assign dly_f      = src[SRC_WIDTH-4-IDX_W-CW -: DLY_W];
  assign unused_src = ^src;

  generate
    if (IDX_W > 0) begin : g_idx
      assign idx_f = src[SRC_WIDTH-4 -: IDX_FW];
    end else begin : g_noidx
      assign idx_f = '0;
    end
  endgenerate

  logic [RUN_WIDTH-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]     head_q, head_d, head_adv, tgt;
  logic [CW-1:0]        inp_q [NUM_INP];
  logic [CW-1:0]        inp_d [NUM_INP];
  logic [CW-1:0]        slot_q [DELAY_DEPTH][NUM_INP];
  logic [CW-1:0]        slot_d [DELAY_DEPTH][NUM_INP];
  logic                 net_rst_q, net_rst_d, drop_q, drop_d, sat_q, sat_d;
  logic                 adv, accept;
  op_e                  op;
  logic [CW:0]          sum;
  int                   t_i;

  // Returns {clamped, result}; the add is done one bit wider so overflow is visible.
  function automatic logic [CW:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {a[CW-1], a} + {b[CW-1], b};
    if (s[CW] != s[CW-1])
      return {1'b1, s[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}}};
    return {1'b0, s[CW-1:0]};
  endfunction

  assign src_ready = (cnt_q <= RUN_WIDTH'(1));
  assign net_valid = (cnt_q != '0);
  assign net_rst   = net_rst_q;
  assign drop      = drop_q;
  assign sat       = sat_q;

  generate
    for (genvar g = 0; g < NUM_INP; g++) begin : g_out
      assign net_inp[g*CW +: CW] = inp_q[g];
    end
  endgenerate

  always_comb begin
    adv       = net_valid && net_ready;
    accept    = src_valid && src_ready;
    op        = OP_NOP;
    cnt_d     = cnt_q;
    inp_d     = inp_q;
    slot_d    = slot_q;
    net_rst_d = 1'b0;
    drop_d    = 1'b0;
    sat_d     = 1'b0;
    sum       = '0;
    t_i       = 0;
    tgt       = '0;
    if (accept) begin
      case (opc)
        3'd1:    op = OP_RUN;
        3'd2:    op = OP_SPK;
        3'd3:    op = OP_CLR;
        default: op = OP_NOP;
      endcase
    end
    // A new RUN replaces the count outright, so a RUN landing on the last step has no bubble.
    if (op == OP_RUN)  cnt_d = (run_f == '0) ? RUN_WIDTH'(1) : run_f;
    else if (adv)      cnt_d = cnt_q - RUN_WIDTH'(1);
    if (adv) head_adv = (int'(head_q) == DELAY_DEPTH - 1) ? '0 : head_q + PTR_W'(1);
    else     head_adv = head_q;
    head_d = head_adv;
    if (adv) begin
      inp_d = slot_q[head_q];
      for (int i = 0; i < NUM_INP; i++) slot_d[head_q][i] = '0;
    end
    if (op == OP_SPK) begin
      if (int'(idx_f) >= NUM_INP || int'(dly_f) > DELAY_DEPTH) begin
        drop_d = 1'b1;
      end else if (dly_f == '0) begin
        sum          = sat_add(inp_d[idx_f], val_f);
        inp_d[idx_f] = sum[CW-1:0];
        sat_d        = sum[CW];
      end else begin
        // Reading slot_d gives a zero base when the target is the slot just drained.
        t_i = int'(head_adv) + int'(dly_f) - 1;
        if (t_i >= DELAY_DEPTH) t_i = t_i - DELAY_DEPTH;
        tgt                = PTR_W'(t_i);
        sum                = sat_add(slot_d[tgt][idx_f], val_f);
        slot_d[tgt][idx_f] = sum[CW-1:0];
        sat_d              = sum[CW];
      end
    end
    if (op == OP_CLR) begin
      for (int i = 0; i < NUM_INP; i++) inp_d[i] = '0;
      for (int d = 0; d < DELAY_DEPTH; d++)
        for (int i = 0; i < NUM_INP; i++) slot_d[d][i] = '0;
      head_d    = '0;
      net_rst_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      head_q    <= '0;
      net_rst_q <= 1'b1;
      drop_q    <= 1'b0;
      sat_q     <= 1'b0;
      for (int i = 0; i < NUM_INP; i++) inp_q[i] <= '0;
      for (int d = 0; d < DELAY_DEPTH; d++)
        for (int i = 0; i < NUM_INP; i++) slot_q[d][i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      net_rst_q <= net_rst_d;
      drop_q    <= drop_d;
      sat_q     <= sat_d;
      inp_q     <= inp_d;
      slot_q    <= slot_d;
    end
  end
endmodule

// File: tb/tb_network_source_sched.sv
// Directed bench for network_source_sched: hand-computed expectations checked one step at a time.
module tb_network_source_sched;
  logic        clk = 1'b0;
  logic        rst, src_valid, src_ready, net_ready, net_valid, net_rst, drop, sat;
  logic [31:0] src;
  logic [31:0] net_inp;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_seq [5];
  logic [31:0] hold;

  always #5 clk = ~clk;

  network_source_sched dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready), .src(src),
    .net_ready(net_ready), .net_valid(net_valid), .net_rst(net_rst), .net_inp(net_inp),
    .drop(drop), .sat(sat)
  );

  function automatic logic [31:0] w_spk(input logic [1:0] idx, input logic [7:0] val,
                                        input logic [2:0] dly);
    return {3'd2, idx, val, dly, 16'h0000};
  endfunction
  function automatic logic [31:0] w_run(input logic [15:0] n);
    return {3'd1, n, 13'h0000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [31:0] w);
    src_valid = 1'b1;
    src       = w;
  endtask

  initial begin
    rst = 1'b1; src_valid = 1'b0; src = '0; net_ready = 1'b0;
    tick(); tick();
    chk("rst_src_ready", {31'b0, src_ready}, 32'd1);
    chk("rst_net_valid", {31'b0, net_valid}, 32'd0);
    chk("rst_net_inp",   net_inp, 32'h0);
    chk("rst_net_rst",   {31'b0, net_rst}, 32'd1);
    chk("rst_drop",      {31'b0, drop}, 32'd0);
    chk("rst_sat",       {31'b0, sat}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_release", {31'b0, net_rst}, 32'd0);

    // SPK dly0 then RUN 1
    send(w_spk(2'd2, 8'd5, 3'd0)); tick();
    chk("spk0_inp", net_inp, 32'h0005_0000);
    send(w_run(16'd1)); tick();
    chk("run1_valid", {31'b0, net_valid}, 32'd1);
    chk("run1_inp",   net_inp, 32'h0005_0000);
    src_valid = 1'b0; net_ready = 1'b1; tick();
    chk("run1_done_valid", {31'b0, net_valid}, 32'd0);
    chk("run1_done_inp",   net_inp, 32'h0);
    chk("run1_done_ready", {31'b0, src_ready}, 32'd1);
    net_ready = 1'b0;

    // head=1: SPK idx1 val3 dly2, then RUN 3
    send(w_spk(2'd1, 8'd3, 3'd2)); tick();
    send(w_run(16'd3)); net_ready = 1'b1; tick();
    chk("run3_step1", net_inp, 32'h0);
    src_valid = 1'b0; tick();
    chk("run3_step2", net_inp, 32'h0);
    tick();
    chk("run3_step3", net_inp, 32'h0000_0300);
    tick();
    chk("run3_after", net_inp, 32'h0);
    chk("run3_valid", {31'b0, net_valid}, 32'd0);
    net_ready = 1'b0;

    // head=0: positive saturation into slot 0
    send(w_spk(2'd0, 8'd100, 3'd1)); tick();
    chk("sat_first", {31'b0, sat}, 32'd0);
    tick();
    chk("sat_pulse", {31'b0, sat}, 32'd1);
    src_valid = 1'b0; tick();
    chk("sat_single", {31'b0, sat}, 32'd0);
    send(w_run(16'd1)); tick();
    src_valid = 1'b0; net_ready = 1'b1; tick();
    chk("sat_delivered", net_inp, 32'h0000_007F);
    net_ready = 1'b0;

    // head=1: out-of-range delay, then dly4 on the last adv wraps the ring
    send(w_spk(2'd0, 8'd9, 3'd5)); tick();
    chk("drop_pulse", {31'b0, drop}, 32'd1);
    chk("drop_nochange", net_inp, 32'h0000_007F);
    src_valid = 1'b0; tick();
    chk("drop_single", {31'b0, drop}, 32'd0);
    send(w_run(16'd2)); tick();
    src_valid = 1'b0; net_ready = 1'b1; tick();
    chk("wrap_ready_last", {31'b0, src_ready}, 32'd1);
    send(w_spk(2'd3, 8'd20, 3'd4)); tick();
    chk("wrap_idle", {31'b0, net_valid}, 32'd0);
    send(w_run(16'd5)); tick();
    src_valid = 1'b0;
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h0; exp_seq[2] = 32'h0;
    exp_seq[3] = 32'h1400_0000; exp_seq[4] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("wrap_step%0d", i + 1), net_inp, exp_seq[i]);
    end
    chk("wrap_end", {31'b0, net_valid}, 32'd0);
    net_ready = 1'b0;

    // head=0: schedule -7 at dly3, CLR lands on the adv that would deliver it
    send(w_spk(2'd3, 8'hF9, 3'd3)); tick();
    send(w_run(16'd3)); tick();
    src_valid = 1'b0; net_ready = 1'b1; tick(); tick();
    chk("clr_ready", {31'b0, src_ready}, 32'd1);
    send({3'd3, 29'h0}); tick();
    chk("clr_net_rst", {31'b0, net_rst}, 32'd1);
    chk("clr_inp",     net_inp, 32'h0);
    chk("clr_valid",   {31'b0, net_valid}, 32'd0);
    src_valid = 1'b0; tick();
    chk("clr_rst_fall", {31'b0, net_rst}, 32'd0);
    send(w_run(16'd4)); tick();
    src_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("clr_step%0d", i + 1), net_inp, 32'h0);
    end
    net_ready = 1'b0;

    // RUN 0 is one timestep
    send(w_run(16'd0)); tick();
    chk("run0_valid", {31'b0, net_valid}, 32'd1);
    src_valid = 1'b0; net_ready = 1'b1; tick();
    chk("run0_one_adv", {31'b0, net_valid}, 32'd0);
    net_ready = 1'b0;

    // head=1: stall during RUN 2
    send(w_spk(2'd1, 8'hFD, 3'd0)); tick();
    chk("neg_spk", net_inp, 32'h0000_FD00);
    send(w_spk(2'd2, 8'd4, 3'd1)); tick();
    send(w_run(16'd2)); tick();
    chk("stall_step1", net_inp, 32'h0000_FD00);
    src_valid = 1'b0; net_ready = 1'b1; tick();
    chk("stall_valid_a", {31'b0, net_valid}, 32'd1);
    chk("stall_step2", net_inp, 32'h0004_0000);
    hold = net_inp;
    net_ready = 1'b0; tick();
    chk("stall_valid_b", {31'b0, net_valid}, 32'd1);
    chk("stall_hold", net_inp, 32'h0004_0000);
    net_ready = 1'b1; tick();
    chk("stall_end", {31'b0, net_valid}, 32'd0);
    chk("stall_inp0", net_inp, 32'h0);

    // zero-bubble RUN on the last step
    send(w_run(16'd1)); tick();
    send(w_run(16'd2)); tick();
    chk("b2b_valid0", {31'b0, net_valid}, 32'd1);
    src_valid = 1'b0; tick();
    chk("b2b_valid1", {31'b0, net_valid}, 32'd1);
    tick();
    chk("b2b_valid2", {31'b0, net_valid}, 32'd0);
    net_ready = 1'b0;

    // negative saturation
    send(w_spk(2'd0, 8'h9C, 3'd0)); tick(); tick();
    chk("negsat_inp", net_inp, 32'h0000_0080);
    chk("negsat_pulse", {31'b0, sat}, 32'd1);
    src_valid = 1'b0;

    // reset mid-run
    send(w_run(16'd3)); tick();
    src_valid = 1'b0; rst = 1'b1; tick();
    chk("midrst_valid", {31'b0, net_valid}, 32'd0);
    chk("midrst_net_rst", {31'b0, net_rst}, 32'd1);
    chk("midrst_inp", net_inp, 32'h0);
    rst = 1'b0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
